// File: rtl/spis_avb_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : spis_avb_cmd_arb
// Purpose  : Round-robin arbiter that funnels several AVB command sources
//            onto the single AVMM burst bridge command interface. It keeps one
//            burst in flight at a time, runs the bridge's rising-edge-start /
//            level-held / done-pulse handshake, and refuses commands the
//            bridge would execute incorrectly (sel == 3 or brstlen == 0).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   s_avmm_clk, s_avmm_rst    clock, synchronous active-high reset
//   req_vld/sel/offset/brstlen/rdnwr   per-requester command (packed, i-th slice)
//   req_gnt                   one-hot, high while owner's burst is on the bridge
//   req_done / req_err        one-cycle completion / error pulses to the owner
//   avmm_sel/offset/brstlen/rdnwr/transvld   command to the bridge
//   avmmtransvld_up           bridge done pulse
//   arb_busy, arb_owner, arb_hang   status
// Configuration
//   AVB_ARB_TIMEOUT_EN  when defined, a BUSY watchdog of TIMEOUT cycles drives
//                       the arbiter into a terminal HANG state.
// ============================================================================
module spis_avb_cmd_arb #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                 s_avmm_clk,
    input  logic                 s_avmm_rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [2*NREQ-1:0]    req_sel,
    input  logic [17*NREQ-1:0]   req_offset,
    input  logic [8*NREQ-1:0]    req_brstlen,
    input  logic [NREQ-1:0]      req_rdnwr,
    output logic [NREQ-1:0]      req_gnt,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [1:0]           avmm_sel,
    output logic [16:0]          avmm_offset,
    output logic [7:0]           avmm_brstlen,
    output logic                 avmm_rdnwr,
    output logic                 avmm_transvld,
    input  logic                 avmmtransvld_up,
    output logic                 arb_busy,
    output logic [2:0]           arb_owner,
    output logic                 arb_hang
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY   = 3'd1,
        ST_GAP    = 3'd2,
        ST_REJECT = 3'd3,
        ST_HANG   = 3'd4
    } state_t;

    state_t          r_state;
    logic [2:0]      r_ptr;

    logic [2:0]      w_winner;
    logic            w_found;
    logic [3:0]      w_idx;
    logic [1:0]      w_sel;
    logic [16:0]     w_off;
    logic [7:0]      w_len;
    logic            w_rd;
    logic            w_legal;
    logic [NREQ-1:0] w_win_oh;
    logic [NREQ-1:0] w_own_oh;

    // Round-robin search starting one past the last winner, wrapping at NREQ.
    // ptr < NREQ and k <= NREQ, so a single conditional subtract is a modulo.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + 4'(k);
            if (w_idx >= 4'(NREQ)) begin
                w_idx = w_idx - 4'(NREQ);
            end
            if (!w_found && req_vld[w_idx[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    // Winner's command fields, sampled only in the arbitration cycle.
    always_comb begin
        w_sel = '0;
        w_off = '0;
        w_len = '0;
        w_rd  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == 3'(i)) begin
                w_sel = req_sel[2*i +: 2];
                w_off = req_offset[17*i +: 17];
                w_len = req_brstlen[8*i +: 8];
                w_rd  = req_rdnwr[i];
            end
        end
    end

    // sel 3 hangs bridge reads; brstlen 0 is mis-sized by the bridge.
    assign w_legal  = (w_sel != 2'd3) && (w_len != 8'd0);
    assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_own_oh = {{(NREQ-1){1'b0}}, 1'b1} << arb_owner;

`ifdef AVB_ARB_TIMEOUT_EN
    logic [15:0] r_tcnt;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign arb_hang         = 1'b0;
`endif

    always_ff @(posedge s_avmm_clk) begin
        if (s_avmm_rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 3'(NREQ-1);
            arb_owner     <= 3'(NREQ-1);
            req_gnt       <= '0;
            req_done      <= '0;
            req_err       <= '0;
            avmm_sel      <= '0;
            avmm_offset   <= '0;
            avmm_brstlen  <= '0;
            avmm_rdnwr    <= 1'b0;
            avmm_transvld <= 1'b0;
            arb_busy      <= 1'b0;
`ifdef AVB_ARB_TIMEOUT_EN
            r_tcnt        <= '0;
            arb_hang      <= 1'b0;
`endif
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|req_vld) begin
                        r_ptr     <= w_winner;
                        arb_owner <= w_winner;
                        if (w_legal) begin
                            avmm_sel      <= w_sel;
                            avmm_offset   <= w_off;
                            avmm_brstlen  <= w_len;
                            avmm_rdnwr    <= w_rd;
                            avmm_transvld <= 1'b1;
                            req_gnt       <= w_win_oh;
                            arb_busy      <= 1'b1;
`ifdef AVB_ARB_TIMEOUT_EN
                            r_tcnt        <= '0;
`endif
                            r_state       <= ST_BUSY;
                        end else begin
                            req_done <= w_win_oh;
                            req_err  <= w_win_oh;
                            r_state  <= ST_REJECT;
                        end
                    end
                end
                ST_BUSY: begin
                    // A done pulse wins over a simultaneous watchdog expiry.
                    if (avmmtransvld_up) begin
                        avmm_transvld <= 1'b0;
                        req_gnt       <= '0;
                        req_done      <= w_own_oh;
                        arb_busy      <= 1'b0;
                        r_state       <= ST_GAP;
                    end
`ifdef AVB_ARB_TIMEOUT_EN
                    else if (r_tcnt == 16'(TIMEOUT-1)) begin
                        avmm_transvld <= 1'b0;
                        req_gnt       <= '0;
                        req_done      <= w_own_oh;
                        req_err       <= w_own_oh;
                        arb_busy      <= 1'b0;
                        arb_hang      <= 1'b1;
                        r_state       <= ST_HANG;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
`endif
                end
                // GAP guarantees one low cycle of transvld for the bridge's
                // edge detector before any following command.
                ST_GAP:    r_state <= ST_IDLE;
                ST_REJECT: r_state <= ST_IDLE;
                ST_HANG:   r_state <= ST_HANG;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spis_avb_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spis_avb_cmd_arb
// Purpose  : Self-checking bench for spis_avb_cmd_arb (NREQ = 3, TIMEOUT = 16).
//            A transaction-level reference model (pending set, round-robin
//            pointer, starvation counters) predicts every grant, command and
//            completion; directed cases are followed by randomized traffic.
//            Build with AVB_ARB_TIMEOUT_EN to include the watchdog case.
// Revision : 1.0  initial release
// ============================================================================
module tb_spis_avb_cmd_arb;

    localparam int NREQ = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_vld;
    logic [2*NREQ-1:0]    req_sel;
    logic [17*NREQ-1:0]   req_offset;
    logic [8*NREQ-1:0]    req_brstlen;
    logic [NREQ-1:0]      req_rdnwr;
    logic [NREQ-1:0]      req_gnt, req_done, req_err;
    logic [1:0]           avmm_sel;
    logic [16:0]          avmm_offset;
    logic [7:0]           avmm_brstlen;
    logic                 avmm_rdnwr, avmm_transvld, up;
    logic                 arb_busy, arb_hang;
    logic [2:0]           arb_owner;

    spis_avb_cmd_arb #(.NREQ(NREQ), .TIMEOUT(16)) dut (
        .s_avmm_clk      (clk),
        .s_avmm_rst      (rst),
        .req_vld         (req_vld),
        .req_sel         (req_sel),
        .req_offset      (req_offset),
        .req_brstlen     (req_brstlen),
        .req_rdnwr       (req_rdnwr),
        .req_gnt         (req_gnt),
        .req_done        (req_done),
        .req_err         (req_err),
        .avmm_sel        (avmm_sel),
        .avmm_offset     (avmm_offset),
        .avmm_brstlen    (avmm_brstlen),
        .avmm_rdnwr      (avmm_rdnwr),
        .avmm_transvld   (avmm_transvld),
        .avmmtransvld_up (up),
        .arb_busy        (arb_busy),
        .arb_owner       (arb_owner),
        .arb_hang        (arb_hang)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          ptr;
    bit          pend  [NREQ];
    int          waitg [NREQ];
    logic [1:0]  m_sel [NREQ];
    logic [16:0] m_off [NREQ];
    logic [7:0]  m_len [NREQ];
    logic        m_rd  [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'd1 << i;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_vld[i]             = pend[i];
            req_sel[2*i +: 2]      = m_sel[i];
            req_offset[17*i +: 17] = m_off[i];
            req_brstlen[8*i +: 8]  = m_len[i];
            req_rdnwr[i]           = m_rd[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int i, input logic [1:0] s, input logic [16:0] o,
                         input logic [7:0] l, input logic r);
        pend[i]  = 1'b1;
        waitg[i] = 0;
        m_sel[i] = s;
        m_off[i] = o;
        m_len[i] = l;
        m_rd[i]  = r;
        drive();
    endtask

    task automatic raise_rand(input int i);
        logic [7:0] l;
        l = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
        raise(i, 2'($urandom_range(0, 3)), 17'($urandom), l, 1'($urandom));
    endtask

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) waitg[i] = 0;
    endtask

    // Serve one command from the IDLE cycle: arbitration edge, lat held
    // BUSY cycles, bridge done, GAP, back in IDLE (or REJECT, IDLE).
    task automatic serve(input int lat, input bit scramble);
        int w;
        bit legal;
        logic [27:0] ef;
        w = pick();
        if (w < 0) return;
        legal = (m_sel[w] != 2'd3) && (m_len[w] != 8'd0);
        ef    = {m_sel[w], m_off[w], m_len[w], m_rd[w]};
        chk("starvation_bound", 32'(waitg[w] <= NREQ - 1), 32'd1);
        for (int i = 0; i < NREQ; i++) if (pend[i] && i != w) waitg[i]++;
        ptr = w;
        up  = 1'b0;
        step();
        chk("owner", 32'(arb_owner), 32'(w));
        if (legal) begin
            chk("grant_transvld", 32'(avmm_transvld), 32'd1);
            chk("grant_gnt", 32'(req_gnt), oh(w));
            chk("grant_busy", 32'(arb_busy), 32'd1);
            chk("grant_fields", 32'({avmm_sel, avmm_offset, avmm_brstlen, avmm_rdnwr}), 32'(ef));
            chk("grant_done", 32'(req_done), 32'd0);
            for (int c = 0; c < lat; c++) begin
                if (scramble) begin
                    m_sel[w] = 2'($urandom);
                    m_off[w] = 17'($urandom);
                    m_len[w] = 8'($urandom);
                    m_rd[w]  = 1'($urandom);
                    for (int i = 0; i < NREQ; i++)
                        if (!pend[i] && $urandom_range(0, 3) == 0) raise_rand(i);
                    drive();
                end
                step();
                chk("busy_transvld", 32'(avmm_transvld), 32'd1);
                chk("busy_fields", 32'({avmm_sel, avmm_offset, avmm_brstlen, avmm_rdnwr}), 32'(ef));
                chk("busy_gnt", 32'(req_gnt), oh(w));
                chk("busy_done", 32'(req_done), 32'd0);
            end
            up = 1'b1;
            step();
            chk("gap_transvld", 32'(avmm_transvld), 32'd0);
            chk("gap_gnt", 32'(req_gnt), 32'd0);
            chk("gap_done", 32'(req_done), oh(w));
            chk("gap_err", 32'(req_err), 32'd0);
            chk("gap_busy", 32'(arb_busy), 32'd0);
            up = 1'($urandom);
        end else begin
            chk("rej_transvld", 32'(avmm_transvld), 32'd0);
            chk("rej_gnt", 32'(req_gnt), 32'd0);
            chk("rej_done", 32'(req_done), oh(w));
            chk("rej_err", 32'(req_err), oh(w));
            chk("rej_busy", 32'(arb_busy), 32'd0);
            up = 1'($urandom);
        end
        pend[w] = 1'b0;
        drive();
        step();
        chk("idle_transvld", 32'(avmm_transvld), 32'd0);
        chk("idle_done", 32'(req_done), 32'd0);
        chk("idle_err", 32'(req_err), 32'd0);
        up = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        drive();
        step();
        step();
        chk("rst_transvld", 32'(avmm_transvld), 32'd0);
        chk("rst_gnt", 32'(req_gnt), 32'd0);
        chk("rst_done_err", 32'({req_done, req_err}), 32'd0);
        chk("rst_owner", 32'(arb_owner), 32'(NREQ - 1));
        chk("rst_status", 32'({arb_busy, arb_hang}), 32'd0);
        chk("rst_fields", 32'({avmm_sel, avmm_offset, avmm_brstlen, avmm_rdnwr}), 32'd0);
        rst = 1'b0;
        reset_model();
        step();
    endtask

    initial begin
        rst = 1'b1;
        up  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; m_sel[i] = '0; m_off[i] = '0; m_len[i] = '0; m_rd[i] = 1'b0;
        end
        drive();
        reset_model();
        do_reset();

        // Idle with no requests
        for (int c = 0; c < 3; c++) begin
            step();
            chk("noreq_gnt", 32'({req_gnt, avmm_transvld, req_done}), 32'd0);
        end

        // Single write, bridge answers 20 cycles after transvld
        raise(0, 2'd1, 17'h00100, 8'd4, 1'b0);
        serve(20, 1'b0);

        // Simultaneous requests after reset: order 0,1,0,1
        do_reset();
        raise_rand(0); raise(0, 2'd0, 17'h1A2B3, 8'd8, 1'b1);
        raise(1, 2'd2, 17'h00040, 8'd2, 1'b0);
        serve(3, 1'b0);
        serve(2, 1'b0);
        raise(0, 2'd1, 17'h00010, 8'd1, 1'b0);
        raise(1, 2'd0, 17'h1FFFF, 8'd255, 1'b1);
        serve(1, 1'b0);
        serve(0, 1'b0);

        // Rejects: sel 3, then brstlen 0 followed by a legal read
        raise(1, 2'd3, 17'h00020, 8'd2, 1'b1);
        serve(0, 1'b0);
        raise(0, 2'd0, 17'h00008, 8'd0, 1'b0);
        serve(0, 1'b0);
        raise(0, 2'd2, 17'h00008, 8'd1, 1'b1);
        serve(4, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) raise_rand(i);
            if (any_pend()) begin
                serve($urandom_range(0, 6), 1'b1);
            end else begin
                step();
                chk("rand_idle", 32'({req_gnt, avmm_transvld, req_done}), 32'd0);
            end
        end
        while (any_pend()) serve($urandom_range(0, 3), 1'b0);

        // Reset in the middle of a burst
        raise(1, 2'd1, 17'h00300, 8'd16, 1'b0);
        step();
        chk("mid_transvld", 32'(avmm_transvld), 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_transvld", 32'(avmm_transvld), 32'd0);
        chk("midrst_gnt", 32'(req_gnt), 32'd0);
        chk("midrst_owner", 32'(arb_owner), 32'(NREQ - 1));
        chk("midrst_busy", 32'(arb_busy), 32'd0);
        rst = 1'b0;
        reset_model();
        serve(5, 1'b0);

`ifdef AVB_ARB_TIMEOUT_EN
        // Bridge never answers: 16 BUSY cycles, then terminal HANG
        raise(2, 2'd0, 17'h00400, 8'd3, 1'b1);
        step();
        chk("to_transvld", 32'(avmm_transvld), 32'd1);
        for (int c = 0; c < 15; c++) begin
            step();
            chk("to_wait", 32'({avmm_transvld, arb_hang, req_done}), 32'({1'b1, 1'b0, 3'b000}));
        end
        step();
        chk("to_done", 32'(req_done), oh(2));
        chk("to_err", 32'(req_err), oh(2));
        chk("to_hang", 32'(arb_hang), 32'd1);
        chk("to_transvld_low", 32'({avmm_transvld, req_gnt}), 32'd0);
        pend[2] = 1'b0;
        drive();
        raise(0, 2'd1, 17'h00001, 8'd1, 1'b0);
        raise(1, 2'd1, 17'h00002, 8'd1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("hang_nogrant", 32'({req_gnt, avmm_transvld, req_done}), 32'd0);
            chk("hang_sticky", 32'(arb_hang), 32'd1);
        end
`else
        step();
        chk("hang_tied_low", 32'(arb_hang), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
